// File: rtl/fifo_burst_sched_pkg.sv
// Shared definitions for the fifo_2048 write arbiter / read burst scheduler.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package fifo_sched_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DEPTH      = 2048;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    BURST = ST_BURST,
    GAP   = ST_GAP
  } state_t;

  // Occupancy must represent 0..depth inclusive, hence one bit above the pointer.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_burst_sched_if.sv
// Bundle of producer, FIFO-strobe and consumer signals around the burst scheduler.
// Latency: n/a (wiring only).
// Backpressure: req_ready grants producers; sink_ready stalls read strobes.
// Ports: slave = scheduler view, master = surrounding producers/FIFO/consumer view.
interface fifo_burst_sched_if #(
  parameter int NUM_REQ   = 4,
  parameter int DataWidth = fifo_sched_pkg::DEF_DATA_WIDTH,
  parameter int Depth     = fifo_sched_pkg::DEF_DEPTH
);
  import fifo_sched_pkg::*;

  localparam int LvlWidth = level_width(Depth);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DataWidth-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         fifo_wr;
  logic [DataWidth-1:0]         fifo_wr_data;
  logic                         fifo_rd;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [DataWidth-1:0]         fifo_data_out;
  logic                         sink_ready;
  logic                         sink_valid;
  logic [DataWidth-1:0]         sink_data;
  logic                         sink_last;
  logic                         flush;
  logic [LvlWidth-1:0]          level;
  logic                         busy;

  modport slave (
    input  req_valid, req_data, fifo_full, fifo_empty, fifo_data_out, sink_ready, flush,
    output req_ready, fifo_wr, fifo_wr_data, fifo_rd, sink_valid, sink_data, sink_last,
           level, busy
  );

  modport master (
    output req_valid, req_data, fifo_full, fifo_empty, fifo_data_out, sink_ready, flush,
    input  req_ready, fifo_wr, fifo_wr_data, fifo_rd, sink_valid, sink_data, sink_last,
           level, busy
  );

endinterface

// File: rtl/fifo_burst_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above the pointer.
// Latency: grant is combinational; pointer advances on the clock after a grant.
// Backpressure: enable=0 suppresses all grants and freezes the pointer.
// Ports: clk, rst (async active-low), req, enable in; grant out.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] idx;
  logic          found;
  int            sum;

  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    idx     = '0;
    found   = 1'b0;
    sum     = 0;
    if (enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found) begin
          // Wrap the search index without a modulo so non-power-of-two counts work.
          sum = int'(ptr) + k;
          if (sum >= NUM_REQ) sum = sum - NUM_REQ;
          idx = PW'(sum);
          if (req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
            ptr_nxt    = (sum == NUM_REQ - 1) ? '0 : PW'(sum + 1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr <= '0;
    else      ptr <= ptr_nxt;
  end

endmodule

// File: rtl/fifo_burst_sched.sv
// Write arbiter and read burst scheduler in front of the shared fifo_2048 buffer.
// Latency: write grant same cycle; sink word one cycle after its fifo_rd strobe.
// Backpressure: no grants while full; sink_ready=0 stalls further fifo_rd strobes.
// Ports: clk, rst (async active-low), bus (slave modport of fifo_burst_sched_if).
module fifo_burst_sched #(
  parameter int DataWidth = fifo_sched_pkg::DEF_DATA_WIDTH,
  parameter int Depth     = fifo_sched_pkg::DEF_DEPTH,
  parameter int PtrWidth  = $clog2(Depth),
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 64
) (
  input logic                clk,
  input logic                rst,
  fifo_burst_sched_if.slave  bus
);
  import fifo_sched_pkg::*;

  localparam int              LvlW    = PtrWidth + 1;
  localparam logic [LvlW-1:0] DEPTH_L = LvlW'(Depth);
  localparam logic [LvlW-1:0] BURST_L = LvlW'(BURST_LEN);
  localparam logic [LvlW-1:0] ONE_L   = LvlW'(1);

  state_t               state, state_nxt;
  logic [LvlW-1:0]      level, beats, beats_nxt;
  logic                 flush_pend;
  logic                 wr_en, rd, last_rd;
  logic [NUM_REQ-1:0]   grant;
  logic [DataWidth-1:0] wr_mux, data_hold;
  logic                 sink_valid_q, sink_last_q;

  // rst is folded in so the combinational strobes drop the moment reset asserts.
  assign wr_en = rst && (level < DEPTH_L) && !bus.fifo_full;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req_valid),
    .enable (wr_en),
    .grant  (grant)
  );

  always_comb begin
    wr_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) wr_mux = wr_mux | bus.req_data[i*DataWidth +: DataWidth];
    end
  end

  assign bus.req_ready    = grant;
  assign bus.fifo_wr      = |grant;
  assign bus.fifo_wr_data = wr_mux;
  assign bus.fifo_rd      = rd;
  assign bus.level        = level;
  assign bus.busy         = (state != IDLE);
  assign bus.sink_valid   = sink_valid_q;
  assign bus.sink_last    = sink_last_q;
  // FIFO read data arrives in the same cycle as sink_valid; hold the last word otherwise.
  assign bus.sink_data    = sink_valid_q ? bus.fifo_data_out : data_hold;

  always_comb begin
    state_nxt = state;
    beats_nxt = beats;
    rd        = 1'b0;
    last_rd   = 1'b0;
    unique case (state)
      IDLE: begin
        if (level >= BURST_L || (flush_pend && level != '0)) begin
          state_nxt = BURST;
          beats_nxt = (level < BURST_L) ? level : BURST_L;
        end
      end
      BURST: begin
        rd = bus.sink_ready && !bus.fifo_empty && (beats != '0);
        if (rd) begin
          beats_nxt = beats - ONE_L;
          if (beats == ONE_L) begin
            last_rd   = 1'b1;
            state_nxt = GAP;
          end
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= '0;
    end else if (bus.fifo_wr && !rd && level != DEPTH_L) begin
      level <= level + ONE_L;
    end else if (rd && !bus.fifo_wr && level != '0) begin
      level <= level - ONE_L;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      beats        <= '0;
      flush_pend   <= 1'b0;
      sink_valid_q <= 1'b0;
      sink_last_q  <= 1'b0;
      data_hold    <= '0;
    end else begin
      state        <= state_nxt;
      beats        <= beats_nxt;
      // Sticky until the buffer has been fully drained while idle.
      flush_pend   <= bus.flush || (flush_pend && !(state == IDLE && level == '0));
      sink_valid_q <= rd;
      sink_last_q  <= last_rd;
      if (sink_valid_q) data_hold <= bus.fifo_data_out;
    end
  end

endmodule

// File: tb/tb_fifo_burst_sched.sv
// Self-checking bench: behavioural FIFO plus queue-based reference for grants, data and level.
// Latency: n/a.
// Backpressure: sink_ready driven randomly and in directed stalls.
module tb_fifo_burst_sched;

  localparam int NREQ  = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 2048;
  localparam int BLEN  = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_burst_sched_if #(.NUM_REQ(NREQ), .DataWidth(DW), .Depth(DEPTH)) bus ();

  fifo_burst_sched #(
    .DataWidth(DW), .Depth(DEPTH), .NUM_REQ(NREQ), .BURST_LEN(BLEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural fifo_2048 ----------------
  logic [DW-1:0] fq[$];
  int            fcnt = 0;
  assign bus.fifo_full  = (fcnt == DEPTH);
  assign bus.fifo_empty = (fcnt == 0);

  always @(posedge clk) begin
    bit rd_ok, wr_ok;
    if (!rst) begin
      fq.delete();
      fcnt              <= 0;
      bus.fifo_data_out <= '0;
    end else begin
      rd_ok = bus.fifo_rd && (fcnt > 0);
      wr_ok = bus.fifo_wr && (fcnt < DEPTH);
      if (rd_ok) bus.fifo_data_out <= fq.pop_front();
      if (wr_ok) fq.push_back(bus.fifo_wr_data);
      fcnt <= fcnt + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
    end
  end

  // ---------------- reference model and monitor ----------------
  int            m_level = 0;
  int            m_ptr   = 0;
  logic [DW-1:0] sb[$];
  int            cur_len = 0;
  int            bursts[$];
  int            rd_cnt  = 0;

  always @(negedge clk) begin
    int            gi;
    int            exp_g;
    logic [DW-1:0] wdat;
    if (!rst) begin
      m_level = 0;
      m_ptr   = 0;
      sb.delete();
      cur_len = 0;
    end else begin
      if (bus.sink_valid) begin
        m_level--;
        if (sb.size() == 0) check("sink_spurious", bus.sink_valid, 0);
        else                check("sink_data", bus.sink_data, sb.pop_front());
        cur_len++;
        if (bus.sink_last) begin
          bursts.push_back(cur_len);
          check("burst_le_max", cur_len <= BLEN, 1);
          cur_len = 0;
        end
      end else begin
        check("last_without_valid", bus.sink_last, 0);
      end
      check("level", bus.level, m_level);
      check("level_le_depth", bus.level <= DEPTH, 1);
      if (!bus.sink_ready) check("rd_while_stalled", bus.fifo_rd, 0);
      if (bus.fifo_rd) rd_cnt++;

      gi = -1;
      if (m_level < DEPTH && !bus.fifo_full) begin
        for (int k = 0; k < NREQ; k++) begin
          int j;
          j = (m_ptr + k) % NREQ;
          if (gi < 0 && ((int'(bus.req_valid) >> j) & 1) == 1) gi = j;
        end
      end
      exp_g = (gi >= 0) ? (1 << gi) : 0;
      check("grant", bus.req_ready, exp_g);
      check("fifo_wr", bus.fifo_wr, gi >= 0);
      if (gi >= 0) begin
        wdat = bus.req_data[gi*DW +: DW];
        check("wr_data", bus.fifo_wr_data, wdat);
        sb.push_back(wdat);
        m_level++;
        m_ptr = (gi + 1) % NREQ;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int ok;
    bus.req_valid  = '0;
    bus.sink_ready = 1'b1;
    cycle();
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    ok = 0;
    for (int i = 0; i < 6000 && ok == 0; i++) begin
      @(negedge clk);
      if (bus.level == 0 && !bus.busy) ok = 1;
    end
    check("drain_done", ok, 1);
    repeat (3) cycle();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.sink_ready = 1'b0;
    bus.flush      = 1'b0;
    rst            = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset mid-write with three producers active
    cycle();
    bus.req_valid = 4'b0111;
    bus.req_data  = {$urandom, $urandom};
    cycle();
    bus.req_data  = {$urandom, $urandom};
    cycle();
    #2;
    check("pre_rst_level", bus.level, 2);
    rst = 1'b0;
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_fifo_wr", bus.fifo_wr, 0);
    check("rst_fifo_rd", bus.fifo_rd, 0);
    check("rst_sink_valid", bus.sink_valid, 0);
    check("rst_sink_last", bus.sink_last, 0);
    check("rst_sink_data", bus.sink_data, 0);
    check("rst_level", bus.level, 0);
    check("rst_busy", bus.busy, 0);
    cycle();
    cycle();
    bus.req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    check("level_after_rst", bus.level, 0);

    // Round robin: all requesters valid for eight cycles
    cycle();
    bus.req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      bus.req_data = {$urandom, $urandom};
      @(negedge clk);
      check("rr_seq", bus.req_ready, 1 << (i % NREQ));
      cycle();
    end
    bus.req_valid = '0;
    @(negedge clk);
    check("rr_level", bus.level, 8);
    drain();

    // Threshold burst: 64 words 1..64 from producer 0
    bursts.delete();
    rd_cnt = 0;
    bus.sink_ready = 1'b1;
    bus.req_valid  = 4'b0001;
    for (int v = 1; v <= BLEN; v++) begin
      bus.req_data = {$urandom, $urandom};
      bus.req_data[DW-1:0] = DW'(v);
      cycle();
    end
    bus.req_valid = '0;
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(negedge clk);
      if (bus.sink_last) found = 1;
    end
    check("thr_last_seen", found, 1);
    if (found == 1) begin
      check("thr_busy_at_last", bus.busy, 1);
      @(negedge clk);
      check("thr_busy_drop", bus.busy, 0);
      check("thr_level", bus.level, 0);
      check("thr_rd_count", rd_cnt, BLEN);
      check("thr_burst_count", bursts.size(), 1);
      if (bursts.size() > 0) check("thr_burst_len", bursts[0], BLEN);
    end
    cycle();

    // Full: fill to Depth with the consumer stalled
    bus.sink_ready = 1'b0;
    bus.req_valid  = 4'b0001;
    for (int i = 0; i < DEPTH + 16; i++) begin
      bus.req_data = {$urandom, $urandom};
      cycle();
    end
    @(negedge clk);
    check("full_level", bus.level, DEPTH);
    check("full_no_grant", bus.req_ready, 0);
    cycle();
    bus.sink_ready = 1'b1;
    @(negedge clk);
    check("full_one_rd", bus.fifo_rd, 1);
    check("full_no_grant_rd", bus.req_ready, 0);
    cycle();
    bus.sink_ready = 1'b0;
    @(negedge clk);
    check("full_refill_grant", bus.req_ready, 1);
    check("full_level_dip", bus.level, DEPTH - 1);
    cycle();
    @(negedge clk);
    check("full_level_back", bus.level, DEPTH);
    drain();

    // Flush partial: 10 words
    bursts.delete();
    bus.sink_ready = 1'b1;
    bus.req_valid  = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      bus.req_data = {$urandom, $urandom};
      cycle();
    end
    drain();
    check("flush10_count", bursts.size(), 1);
    if (bursts.size() > 0) check("flush10_len", bursts[0], 10);

    // Flush partial: 130 words -> 64, 64, 2
    bursts.delete();
    bus.sink_ready = 1'b1;
    bus.req_valid  = 4'b0010;
    for (int i = 0; i < 130; i++) begin
      bus.req_data = {$urandom, $urandom};
      cycle();
    end
    drain();
    check("flush130_count", bursts.size(), 3);
    if (bursts.size() == 3) begin
      check("flush130_b0", bursts[0], 64);
      check("flush130_b1", bursts[1], 64);
      check("flush130_b2", bursts[2], 2);
    end

    // Concurrent random traffic with a toggling consumer
    for (int i = 0; i < 3000; i++) begin
      bus.req_valid  = NREQ'($urandom);
      bus.req_data   = {$urandom, $urandom};
      bus.sink_ready = ($urandom_range(0, 3) != 0);
      bus.flush      = ($urandom_range(0, 150) == 0);
      cycle();
    end
    bus.flush = 1'b0;
    drain();
    check("sb_empty_end", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
